// File: rtl/mini_alu_pipe.sv
// mini_alu_pipe: two-stage (fetch/decode -> execute) parameterised mini core.
// Asynchronous instruction ROM at oIP, write-through register file and LED latch.
// Optional iterative shift-add multiplier enabled by defining MINI_ALU_MUL_EN;
// without it opcode 7 is a NOP and oBusy is tied low.
module mini_alu_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int IP_WIDTH   = 16,
  parameter int LED_WIDTH  = 8
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [4+3*ADDR_WIDTH-1:0]   iInstruction,
  output logic [IP_WIDTH-1:0]         oIP,
  output logic [LED_WIDTH-1:0]        oLed,
  output logic                        oBusy
);

  localparam int IW    = 4 + 3*ADDR_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LED = 4'd1;
  localparam logic [3:0] OP_BLE = 4'd2;
  localparam logic [3:0] OP_STO = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  logic [3:0]            f_op;
  logic [ADDR_WIDTH-1:0] f_dest, f_src1, f_src0;

  logic [IP_WIDTH-1:0]   pc_q, pc_d;
  logic [3:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d, src1_q, src1_d, src0_q, src0_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd0_q, rd0_d;
  logic [LED_WIDTH-1:0]  led_q, led_d;
  logic [DATA_WIDTH-1:0] rf_q [DEPTH];

  logic                  br_taken, rf_we, stall;
  logic [DATA_WIDTH-1:0] wdata;

  assign f_op   = iInstruction[IW-1 -: 4];
  assign f_dest = iInstruction[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign f_src1 = iInstruction[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign f_src0 = iInstruction[ADDR_WIDTH-1:0];
  assign oLed   = led_q;

`ifdef MINI_ALU_MUL_EN
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mc_q, mc_d, mp_q, mp_d, acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mc_cur, mp_cur, acc_cur, mul_sum;
  logic                  mul_act, mul_first, mul_last;

  // One shift-add step per EX cycle; first cycle takes operands straight from the read registers.
  always_comb begin
    mul_act   = (op_q == OP_MUL);
    mul_first = (cnt_q == '0);
    mul_last  = mul_act && (cnt_q == CW'(DATA_WIDTH-1));
    mc_cur    = mul_first ? rd1_q : mc_q;
    mp_cur    = mul_first ? rd0_q : mp_q;
    acc_cur   = mul_first ? '0    : acc_q;
    mul_sum   = acc_cur + (mp_cur[0] ? mc_cur : '0);
    cnt_d     = cnt_q;
    mc_d      = mc_q;
    mp_d      = mp_q;
    acc_d     = acc_q;
    if (mul_act) begin
      cnt_d = mul_last ? '0 : cnt_q + CW'(1);
      mc_d  = mc_cur << 1;
      mp_d  = mp_cur >> 1;
      acc_d = mul_sum;
    end
  end

  // Multiplier state; reset aborts a running multiply.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
      acc_q <= acc_d;
    end
  end

  // MUL stays in the decode register for the whole stall, so busy follows it directly.
  assign oBusy = mul_act;
`else
  assign oBusy = 1'b0;
`endif

  // Execute decode, branch redirect, next fetch PC and write-through register reads.
  always_comb begin
    br_taken = 1'b0;
    rf_we    = 1'b0;
    stall    = 1'b0;
    wdata    = '0;
    led_d    = led_q;
    case (op_q)
      OP_LED: led_d = rd1_q[LED_WIDTH-1:0];
      OP_BLE: br_taken = (rd1_q <= rd0_q);
      OP_STO: begin
        rf_we = 1'b1;
        wdata = DATA_WIDTH'({src1_q, src0_q});
      end
      OP_ADD: begin
        rf_we = 1'b1;
        wdata = rd1_q + rd0_q;
      end
      OP_JMP: br_taken = 1'b1;
      OP_SUB: begin
        rf_we = 1'b1;
        wdata = rd1_q - rd0_q;
      end
`ifdef MINI_ALU_MUL_EN
      OP_MUL: begin
        stall = !mul_last;
        rf_we = mul_last;
        wdata = mul_sum;
      end
`endif
      default: ;
    endcase

    oIP  = br_taken ? IP_WIDTH'(dest_q) : pc_q;
    pc_d = stall ? pc_q : oIP + IP_WIDTH'(1);

    if (stall) begin
      op_d   = op_q;
      dest_d = dest_q;
      src1_d = src1_q;
      src0_d = src0_q;
      rd1_d  = rd1_q;
      rd0_d  = rd0_q;
    end else begin
      op_d   = f_op;
      dest_d = f_dest;
      src1_d = f_src1;
      src0_d = f_src0;
      rd1_d  = (rf_we && (dest_q == f_src1)) ? wdata : rf_q[f_src1];
      rd0_d  = (rf_we && (dest_q == f_src0)) ? wdata : rf_q[f_src0];
    end
  end

  // Pipeline registers; reset loads a NOP so no write can be pending.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q   <= '0;
      op_q   <= OP_NOP;
      dest_q <= '0;
      src1_q <= '0;
      src0_q <= '0;
      rd1_q  <= '0;
      rd0_q  <= '0;
      led_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      op_q   <= op_d;
      dest_q <= dest_d;
      src1_q <= src1_d;
      src0_q <= src0_d;
      rd1_q  <= rd1_d;
      rd0_q  <= rd0_d;
      led_q  <= led_d;
    end
  end

  // Register file storage, not reset; writes only come from a valid EX op.
  always_ff @(posedge Clock) begin
    if (rf_we) rf_q[dest_q] <= wdata;
  end

endmodule

// File: tb/tb_mini_alu_pipe.sv
// Bench for mini_alu_pipe: ROM model, per-cycle expected (oIP, oLed, oBusy) scoreboard.
module tb_mini_alu_pipe;

  localparam int IW = 28;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [IW-1:0] iInstruction;
  logic [15:0]   oIP;
  logic [7:0]    oLed;
  logic          oBusy;

  logic [IW-1:0] rom [65536];

  typedef struct {
    logic [15:0] ip;
    logic [7:0]  led;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mini_alu_pipe #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .IP_WIDTH(16), .LED_WIDTH(8)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iInstruction(iInstruction),
    .oIP(oIP), .oLed(oLed), .oBusy(oBusy)
  );

  always #5 Clock = ~Clock;
  always_comb iInstruction = rom[oIP];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [IW-1:0] sto(input logic [7:0] d, input logic [15:0] imm);
    return {4'd3, d, imm[15:8], imm[7:0]};
  endfunction

  task automatic rom_clear();
    for (int i = 0; i < 65536; i++) rom[i] = '0;
  endtask

  task automatic push_exp(input logic [15:0] ip, input logic [7:0] led, input logic busy);
    exp_t e;
    e.ip = ip; e.led = led; e.busy = busy;
    sb_q.push_back(e);
  endtask

  // Hold reset two cycles, check reset outputs, release on a falling edge.
  task automatic reset_dut();
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    #1;
    check_val("rst_ip", oIP, 0);
    check_val("rst_led", oLed, 0);
    check_val("rst_busy", oBusy, 0);
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  // Called on a falling edge; pops one expectation per cycle; ends at the last sample time.
  task automatic run_sb(input string name);
    exp_t e;
    int k = 0;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val($sformatf("%s_ip%0d", name, k), oIP, e.ip);
      check_val($sformatf("%s_led%0d", name, k), oLed, e.led);
      check_val($sformatf("%s_busy%0d", name, k), oBusy, e.busy);
      k++;
      if (sb_q.size() > 0) begin
        @(negedge Clock);
        #1;
      end
    end
  endtask

  initial begin
    int cyc;

    // Reset release and first LED
    rom_clear();
    rom[0] = sto(1, 16'h00A5);
    rom[1] = ins(1, 0, 1, 0);
    for (int k = 0; k < 5; k++) push_exp(16'(k), (k >= 3) ? 8'hA5 : 8'h00, 1'b0);
    reset_dut();
    run_sb("boot");
    Reset = 1'b0;
    #1;
    check_val("hold_led", oLed, 0);
    check_val("hold_ip", oIP, 0);

    // Dependent chain through write-through
    rom_clear();
    rom[0] = sto(1, 16'd3);
    rom[1] = sto(2, 16'd4);
    rom[2] = ins(4, 3, 2, 1);
    rom[3] = ins(6, 4, 3, 1);
    rom[4] = ins(1, 0, 4, 0);
    for (int k = 0; k < 8; k++) push_exp(16'(k), (k >= 6) ? 8'h04 : 8'h00, 1'b0);
    reset_dut();
    run_sb("chain");

    // BLE taken, then branch-to-self loop
    rom_clear();
    rom[0]  = sto(1, 16'd5);
    rom[1]  = sto(2, 16'd5);
    rom[2]  = ins(2, 10, 2, 1);
    rom[3]  = sto(6, 16'h0033);
    rom[4]  = ins(1, 0, 6, 0);
    rom[10] = ins(1, 0, 2, 0);
    rom[11] = ins(5, 11, 0, 0);
    push_exp(0, 0, 0); push_exp(1, 0, 0); push_exp(2, 0, 0); push_exp(10, 0, 0);
    push_exp(11, 0, 0); push_exp(11, 5, 0); push_exp(11, 5, 0); push_exp(11, 5, 0);
    reset_dut();
    run_sb("ble_t");

    // BLE not taken falls through to address 3
    rom[1] = sto(2, 16'd6);
    for (int k = 0; k < 8; k++) push_exp(16'(k), (k >= 6) ? 8'h33 : 8'h00, 1'b0);
    reset_dut();
    run_sb("ble_nt");

    // Opcodes 8..15 do nothing
    rom_clear();
    rom[0] = sto(1, 16'h0011);
    rom[1] = ins(8, 1, 1, 1);
    rom[2] = ins(12, 1, 1, 1);
    rom[3] = ins(13, 20, 0, 0);
    rom[4] = ins(1, 0, 1, 0);
    for (int k = 0; k < 8; k++) push_exp(16'(k), (k >= 6) ? 8'h11 : 8'h00, 1'b0);
    reset_dut();
    run_sb("nop8");

`ifdef MINI_ALU_MUL_EN
    // Multiply: 16-cycle stall, truncated product, dependent readers
    rom_clear();
    rom[0] = sto(1, 16'h0102);
    rom[1] = sto(2, 16'h0300);
    rom[2] = sto(5, 16'h05FF);
    rom[3] = ins(7, 3, 1, 2);
    rom[4] = ins(1, 0, 3, 0);
    rom[5] = ins(6, 4, 3, 5);
    rom[6] = ins(1, 0, 4, 0);
    for (int k = 0; k < 25; k++)
      push_exp((k < 4) ? 16'(k) : ((k <= 19) ? 16'd4 : 16'(k - 15)),
               (k >= 23) ? 8'h01 : 8'h00, (k >= 4) && (k <= 19));
    reset_dut();
    run_sb("mul");

    // Reset in the fifth multiply cycle
    rom_clear();
    rom[0] = sto(3, 16'h0042);
    rom[1] = sto(1, 16'h0102);
    rom[2] = sto(2, 16'h0300);
    rom[3] = ins(7, 3, 1, 2);
    for (int k = 0; k < 9; k++) push_exp((k < 4) ? 16'(k) : 16'd4, 8'h00, k >= 4);
    reset_dut();
    run_sb("mulab");
    Reset = 1'b0;
    #1;
    check_val("mulab_busy", oBusy, 0);
    check_val("mulab_ip", oIP, 0);
    rom_clear();
    rom[0] = ins(1, 0, 3, 0);
    push_exp(0, 0, 0); push_exp(1, 0, 0); push_exp(2, 8'h42, 0); push_exp(3, 8'h42, 0);
    @(negedge Clock);
    Reset = 1'b1;
    run_sb("mulab_r3");
`else
    // Opcode 7 is a NOP without the multiplier
    rom_clear();
    rom[0] = sto(3, 16'h0042);
    rom[1] = sto(1, 16'd3);
    rom[2] = ins(7, 3, 1, 1);
    rom[3] = ins(1, 0, 3, 0);
    for (int k = 0; k < 7; k++) push_exp(16'(k), (k >= 5) ? 8'h42 : 8'h00, 1'b0);
    reset_dut();
    run_sb("op7");
`endif

    // Sequential fetch to 0xFFFF, JMP 0 there, PC wraps
    rom_clear();
    rom[65535] = ins(5, 0, 0, 0);
    rom[1]     = sto(7, 16'h003C);
    rom[2]     = ins(1, 0, 7, 0);
    reset_dut();
    cyc = 0;
    #1;
    while (oIP != 16'hFFFF && cyc < 70000) begin
      @(negedge Clock);
      #1;
      cyc++;
    end
    check_val("wrap_reach", oIP, 16'hFFFF);
    check_val("wrap_led", oLed, 8'h3C);
    for (int k = 0; k < 4; k++) push_exp(16'(k), 8'h3C, 1'b0);
    @(negedge Clock);
    run_sb("wrap");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
